pixel_sort_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-pixel sort engine. It accepts 8×16-bit pixel groups from two upstream channels (A, B) over valid/ready handshakes and grants them round-robin. It issues the winner's group to the sort engine with a one-cycle enable and captures the engine's registered result. It returns the result to the owning channel over a valid/ready response handshake. One group is in flight at a time; a watchdog recovers from a missing engine result.

---
 rtl/pixel_sort_arb.sv | 123 ++++++++++++
 tb/tb_pixel_sort_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sort_arb.sv
// Round-robin arbiter/sequencer between two pixel-group channels and a shared
// 8-pixel sort engine; one group in flight, watchdog-protected result wait.
module pixel_sort_arb #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         soft_rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [127:0] a_pix,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [127:0] b_pix,
  output logic         a_resp_valid,
  input  logic         a_resp_ready,
  output logic         b_resp_valid,
  input  logic         b_resp_ready,
  output logic [127:0] resp_pix,
  output logic         sort_enable,
  output logic [127:0] sort_pix,
  output logic         sort_soft_rst,
  input  logic [127:0] sort_res,
  input  logic         sort_valid,
  output logic         busy,
  output logic         owner,
  output logic         err_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [127:0]    hold_q, res_q;
  logic [CW-1:0]   cnt_q;
  logic            owner_q;
  logic            abort;
  logic            grant_a, grant_b;
  logic            cnt_done;

  always_comb begin
    abort        = !reset_n || soft_rst;
    state_nx     = state;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    a_resp_valid = 1'b0;
    b_resp_valid = 1'b0;
    sort_enable  = 1'b0;
    err_timeout  = 1'b0;
    cnt_done     = (cnt_q == CW'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        // On contention the channel that did not win last time goes first.
        grant_a = a_valid && (!b_valid || owner_q);
        grant_b = b_valid && (!a_valid || !owner_q);
        if (grant_a || grant_b) state_nx = ISSUE;
      end
      ISSUE: begin
        sort_enable = 1'b1;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (sort_valid) begin
          state_nx = RESP;
        end else if (cnt_done) begin
          err_timeout = 1'b1;
          state_nx    = IDLE;
        end
      end
      RESP: begin
        a_resp_valid = !owner_q;
        b_resp_valid = owner_q;
        if (owner_q ? b_resp_ready : a_resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Any abort silences every handshake and pulse in its own cycle.
    if (abort) begin
      grant_a      = 1'b0;
      grant_b      = 1'b0;
      a_resp_valid = 1'b0;
      b_resp_valid = 1'b0;
      sort_enable  = 1'b0;
      err_timeout  = 1'b0;
      state_nx     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (abort) begin
      state  <= IDLE;
      hold_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      if (!reset_n) owner_q <= 1'b1;
    end else begin
      state <= state_nx;
      if (grant_a) begin
        hold_q  <= a_pix;
        owner_q <= 1'b0;
      end else if (grant_b) begin
        hold_q  <= b_pix;
        owner_q <= 1'b1;
      end
      if (state == ISSUE) begin
        cnt_q <= '0;
      end else if (state == WAIT && !sort_valid) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state == WAIT && sort_valid) res_q <= sort_res;
    end
  end

  assign a_ready       = grant_a;
  assign b_ready       = grant_b;
  assign resp_pix      = res_q;
  assign sort_pix      = hold_q;
  assign sort_soft_rst = soft_rst;
  assign busy          = (state != IDLE);
  assign owner         = owner_q;

endmodule

// File: tb/tb_pixel_sort_arb.sv
// Directed bench for pixel_sort_arb with a behavioural one-cycle sort engine;
// a cycle table covers single-request and contention, hand sequences the rest.
module tb_pixel_sort_arb;

  logic         clk = 1'b0;
  logic         reset_n, soft_rst;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic [127:0] a_pix, b_pix, resp_pix, sort_pix, sort_res;
  logic         a_resp_valid, a_resp_ready, b_resp_valid, b_resp_ready;
  logic         sort_enable, sort_soft_rst, sort_valid;
  logic         busy, owner, err_timeout;

  logic         eng_on, stray, eng_valid;
  logic [127:0] eng_res;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pixel_sort_arb #(.TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .soft_rst(soft_rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_pix(a_pix),
    .b_valid(b_valid), .b_ready(b_ready), .b_pix(b_pix),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .resp_pix(resp_pix), .sort_enable(sort_enable), .sort_pix(sort_pix),
    .sort_soft_rst(sort_soft_rst), .sort_res(sort_res), .sort_valid(sort_valid),
    .busy(busy), .owner(owner), .err_timeout(err_timeout)
  );

  function automatic logic [127:0] sort8(input logic [127:0] x);
    logic [15:0] p[8];
    logic [15:0] t;
    logic [127:0] r;
    for (int i = 0; i < 8; i++) p[i] = x[16*i +: 16];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (p[j] > p[j+1]) begin
          t = p[j]; p[j] = p[j+1]; p[j+1] = t;
        end
    for (int i = 0; i < 8; i++) r[16*i +: 16] = p[i];
    return r;
  endfunction

  function automatic logic [127:0] pk(input int p1, p2, p3, p4, p5, p6, p7, p8);
    return {16'(p8), 16'(p7), 16'(p6), 16'(p5), 16'(p4), 16'(p3), 16'(p2), 16'(p1)};
  endfunction

  // behavioural engine: registers the sorted group one edge after enable
  always @(posedge clk) begin
    if (!reset_n || sort_soft_rst) begin
      eng_valid <= 1'b0;
      eng_res   <= '0;
    end else begin
      eng_valid <= eng_on && sort_enable;
      if (sort_enable) eng_res <= sort8(sort_pix);
    end
  end
  assign sort_res   = eng_res;
  assign sort_valid = eng_valid | stray;

  logic [7:0] outs;
  assign outs = {a_ready, b_ready, sort_enable, a_resp_valid, b_resp_valid, busy, owner, err_timeout};

  typedef struct {
    logic       av, bv;
    logic [7:0] exp;
    int         pix_sel;  // 0 none, 1 resp_pix, 2 sort_pix
    logic [127:0] xp;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t v(input logic av, bv, input logic [7:0] e, input int sel,
                             input logic [127:0] xp);
    vec_t r;
    r.av = av; r.bv = bv; r.exp = e; r.pix_sel = sel; r.xp = xp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  logic [127:0] PA, PB, SA, SB;

  task automatic do_req(input logic ch, input logic [127:0] exp);
    nxt(); a_valid = !ch; b_valid = ch; a_resp_ready = 1'b1; b_resp_ready = 1'b1; #1;
    chk("req_ready", {a_ready, b_ready}, ch ? 2'b01 : 2'b10);
    nxt(); a_valid = 1'b0; b_valid = 1'b0; #1;
    chk("req_issue", sort_enable, 1'b1);
    nxt(); #1;
    chk("req_wait", {sort_enable, busy}, 2'b01);
    nxt(); #1;
    chk("req_rv", {a_resp_valid, b_resp_valid}, ch ? 2'b01 : 2'b10);
    chk("req_pix", resp_pix, exp);
    nxt(); #1;
    chk("req_idle", busy, 1'b0);
  endtask

  initial begin
    PA = pk(3, 9, 1, 7, 5, 2, 8, 4);
    SA = pk(1, 2, 3, 4, 5, 7, 8, 9);
    PB = pk(100, 50, 200, 10, 65535, 0, 30, 70);
    SB = pk(0, 10, 30, 50, 70, 100, 200, 65535);

    // bits: a_ready b_ready sort_enable a_resp_valid b_resp_valid busy owner err_timeout
    tbl[0]  = v(1, 0, 8'b1000_0010, 0, '0);
    tbl[1]  = v(0, 0, 8'b0010_0100, 2, PA);
    tbl[2]  = v(0, 0, 8'b0000_0100, 0, '0);
    tbl[3]  = v(0, 0, 8'b0001_0100, 1, SA);
    tbl[4]  = v(1, 1, 8'b0100_0000, 0, '0);
    tbl[5]  = v(1, 1, 8'b0010_0110, 2, PB);
    tbl[6]  = v(1, 1, 8'b0000_0110, 0, '0);
    tbl[7]  = v(1, 1, 8'b0000_1110, 1, SB);
    tbl[8]  = v(1, 1, 8'b1000_0010, 0, '0);
    tbl[9]  = v(1, 1, 8'b0010_0100, 2, PA);
    tbl[10] = v(1, 1, 8'b0000_0100, 0, '0);
    tbl[11] = v(1, 1, 8'b0001_0100, 1, SA);
    tbl[12] = v(1, 1, 8'b0100_0000, 0, '0);
    tbl[13] = v(1, 1, 8'b0010_0110, 2, PB);
    tbl[14] = v(1, 1, 8'b0000_0110, 0, '0);
    tbl[15] = v(1, 1, 8'b0000_1110, 1, SB);
    tbl[16] = v(0, 0, 8'b0000_0010, 0, '0);

    reset_n = 1'b0; soft_rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_resp_ready = 1'b1; b_resp_ready = 1'b1; a_pix = PA; b_pix = PB;
    eng_on = 1'b1; stray = 1'b0;
    repeat (2) nxt();
    soft_rst = 1'b1; #1;
    chk("soft_rst_mirror", sort_soft_rst, 1'b1);
    nxt(); soft_rst = 1'b0; #1;
    chk("reset_outs", outs, 8'b0000_0010);
    chk("reset_resp_pix", resp_pix, '0);
    chk("reset_sort_pix", sort_pix, '0);
    chk("reset_soft_mirror", sort_soft_rst, 1'b0);
    nxt(); reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      nxt(); a_valid = tbl[i].av; b_valid = tbl[i].bv; #1;
      chk($sformatf("tbl%0d_outs", i), outs, tbl[i].exp);
      if (tbl[i].pix_sel == 1) chk($sformatf("tbl%0d_resp_pix", i), resp_pix, tbl[i].xp);
      if (tbl[i].pix_sel == 2) chk($sformatf("tbl%0d_sort_pix", i), sort_pix, tbl[i].xp);
    end

    // backpressure on A with B waiting
    nxt(); a_valid = 1'b1; a_resp_ready = 1'b0; b_resp_ready = 1'b0; #1;
    chk("bp_accept", {a_ready, b_ready}, 2'b10);
    nxt(); a_valid = 1'b0; #1;
    nxt();
    nxt(); b_valid = 1'b1; b_resp_ready = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin nxt(); #1; end
      chk("bp_rv", {a_resp_valid, b_resp_valid}, 2'b10);
      chk("bp_pix", resp_pix, SA);
      chk("bp_ready", {a_ready, b_ready}, 2'b00);
    end
    nxt(); a_resp_ready = 1'b1; #1;
    chk("bp_handshake", {a_resp_valid, a_ready, b_ready}, 3'b100);
    nxt(); a_resp_ready = 1'b0; #1;
    chk("bp_next_grant", {a_resp_valid, a_ready, b_ready}, 3'b001);
    nxt(); b_valid = 1'b0; #1;
    chk("bp_b_issue", {sort_enable, owner}, 2'b11);
    nxt();
    nxt(); #1;
    chk("bp_b_rv", {a_resp_valid, b_resp_valid}, 2'b01);
    chk("bp_b_pix", resp_pix, SB);
    nxt(); #1;
    chk("bp_b_idle", busy, 1'b0);

    // watchdog: engine silent
    eng_on = 1'b0; a_resp_ready = 1'b1;
    nxt(); a_valid = 1'b1; #1;
    chk("to_accept", a_ready, 1'b1);
    nxt(); a_valid = 1'b0; #1;
    chk("to_issue", sort_enable, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      nxt(); #1;
      chk($sformatf("to_err_w%0d", i), err_timeout, logic'(i == 8));
      chk($sformatf("to_rv_w%0d", i), {a_resp_valid, b_resp_valid, busy}, 3'b001);
    end
    nxt(); #1;
    chk("to_after", {busy, err_timeout, a_resp_valid}, 3'b000);
    eng_on = 1'b1;
    do_req(1'b0, SA);

    // soft_rst during WAIT
    nxt(); a_valid = 1'b1; #1;
    chk("sr_accept", a_ready, 1'b1);
    nxt(); a_valid = 1'b0;
    nxt(); soft_rst = 1'b1; #1;
    chk("sr_wait", {sort_soft_rst, err_timeout, a_resp_valid, b_resp_valid}, 4'b1000);
    nxt(); soft_rst = 1'b0; #1;
    chk("sr_idle", {busy, a_resp_valid, err_timeout, sort_soft_rst, owner}, 5'b00000);
    chk("sr_hold_clr", sort_pix, '0);
    nxt(); #1;
    chk("sr_quiet", {busy, a_resp_valid, b_resp_valid, err_timeout}, 4'b0000);

    // reset_n during RESP, then A must win contention
    nxt(); a_valid = 1'b1; a_resp_ready = 1'b0; #1;
    chk("rn_accept", a_ready, 1'b1);
    nxt(); a_valid = 1'b0;
    nxt();
    nxt(); #1;
    chk("rn_resp", a_resp_valid, 1'b1);
    nxt(); reset_n = 1'b0; #1;
    chk("rn_during", {a_resp_valid, b_resp_valid, a_ready, b_ready}, 4'b0000);
    nxt(); reset_n = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_resp_ready = 1'b1; #1;
    chk("rn_after", {busy, owner, a_resp_valid, err_timeout}, 4'b0100);
    chk("rn_res_clr", resp_pix, '0);
    chk("rn_a_wins", {a_ready, b_ready}, 2'b10);
    nxt(); a_valid = 1'b0; b_valid = 1'b0; #1;
    chk("rn_issue", {sort_enable, owner}, 2'b10);
    nxt();
    nxt(); #1;
    chk("rn_resp_pix", {a_resp_valid, resp_pix}, {1'b1, SA});
    nxt(); #1;

    // stray sort_valid while idle
    nxt(); stray = 1'b1; #1;
    chk("stray_now", {a_resp_valid, b_resp_valid, busy}, 3'b000);
    nxt(); stray = 1'b0; #1;
    chk("stray_after", {a_resp_valid, b_resp_valid, busy}, 3'b000);
    nxt(); #1;
    chk("stray_later", {a_resp_valid, b_resp_valid, busy}, 3'b000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
